ov7670_capture_ctrl: RTL and testbench

//  Parametrised OV7670 frame-capture writer: assembles byte pairs into 16-bit pixels, optionally

---
 rtl/ov7670_pkg.sv | 23 ++
 rtl/ov7670_byte_assembler.sv | 31 +++
 rtl/ov7670_capture_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_ov7670_capture_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared types and helpers for the OV7670 capture path.
// FSM states, default geometry and decimation legality.
package ov7670_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE
  } cap_state_t;

  localparam int H_ACT_DEF = 640;
  localparam int V_ACT_DEF = 480;
  localparam int Y_W       = 11;

  function automatic bit decim_ok(input int d);
    return (d == 1) || (d == 2) || (d == 4);
  endfunction

  function automatic int decim_shift(input int d);
    return (d == 4) ? 2 : ((d == 2) ? 1 : 0);
  endfunction

endpackage

// File: rtl/ov7670_byte_assembler.sv
// Pairs camera bytes into 16-bit pixels.
// pix_valid is high on the cycle the second byte is presented.
module ov7670_byte_assembler (
  input  logic        pclk,
  input  logic        reset,
  input  logic        clr,
  input  logic        en,
  input  logic        byte_swap,
  input  logic [7:0]  data,
  output logic        pix_valid,
  output logic [15:0] pix_data
);

  logic       phase;
  logic [7:0] byte0;

  always_ff @(posedge pclk) begin
    if (reset || clr) begin
      phase <= 1'b0;
      byte0 <= 8'h00;
    end else if (en) begin
      if (!phase) byte0 <= data;
      phase <= ~phase;
    end
  end

  assign pix_valid = en & phase;
  assign pix_data  = byte_swap ? {data, byte0}
                               : {byte0, data};

endmodule

// File: rtl/ov7670_capture_ctrl.sv
// OV7670 frame capture writer: sync edges, frame FSM,
// decimation counters, address pointer and status flags.
module ov7670_capture_ctrl
  import ov7670_pkg::*;
#(
  parameter int H_ACT  = H_ACT_DEF,
  parameter int V_ACT  = V_ACT_DEF,
  parameter int DECIM  = 2,
  parameter int ADDR_W = 17
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              href,
  input  logic              v_sync,
  input  logic [7:0]        ov7670_data,
  input  logic              cap_en,
  input  logic              single_shot,
  input  logic              byte_swap,
  output logic              we,
  output logic [ADDR_W-1:0] wAddr,
  output logic [15:0]       wData,
  output logic              busy,
  output logic              frame_done,
  output logic [15:0]       frame_cnt,
  output logic              line_err,
  output logic              frame_err
);

  localparam int SH = decim_shift(DECIM);
  localparam int XW = $clog2(H_ACT + 1) + 1;
  localparam int YW = Y_W;

  localparam logic [XW-1:0]     H_L   = XW'(H_ACT);
  localparam logic [YW-1:0]     V_L   = YW'(V_ACT);
  localparam logic [XW-1:0]     DM_X  = XW'(DECIM - 1);
  localparam logic [YW-1:0]     DM_Y  = YW'(DECIM - 1);
  localparam logic [ADDR_W-1:0] W_L   = ADDR_W'(H_ACT / DECIM);
  localparam logic [XW-1:0]     X_MAX = '1;
  localparam logic [YW-1:0]     Y_MAX = '1;

  if (!decim_ok(DECIM)) begin : g_bad_decim
    $error("DECIM must be 1, 2 or 4");
  end

  logic       hr_q, hr_q2, vs_q, vs_q2;
  logic [7:0] d_q;

  always_ff @(posedge pclk) begin
    if (reset) begin
      hr_q  <= 1'b0;
      hr_q2 <= 1'b0;
      vs_q  <= 1'b0;
      vs_q2 <= 1'b0;
      d_q   <= 8'h00;
    end else begin
      hr_q  <= href;
      hr_q2 <= hr_q;
      vs_q  <= v_sync;
      vs_q2 <= vs_q;
      d_q   <= ov7670_data;
    end
  end

  logic hr_fall, vs_fall, vs_rise;

  assign hr_fall = hr_q2 & ~hr_q;
  assign vs_fall = vs_q2 & ~vs_q;
  assign vs_rise = ~vs_q2 & vs_q;

  cap_state_t        state;
  logic              shot_lock;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [ADDR_W-1:0] line_base;

  logic        asm_en, asm_clr;
  logic        pix_valid;
  logic [15:0] pix_data;

  assign asm_en  = (state == CAPTURE) && hr_q;
  assign asm_clr = hr_fall || (state != CAPTURE);

  ov7670_byte_assembler u_asm (
    .pclk      (pclk),
    .reset     (reset),
    .clr       (asm_clr),
    .en        (asm_en),
    .byte_swap (byte_swap),
    .data      (d_q),
    .pix_valid (pix_valid),
    .pix_data  (pix_data)
  );

  logic [YW-1:0]     y_nxt;
  logic              keep;
  logic              base_step;
  logic [ADDR_W-1:0] addr;

  // Line closes before the frame check, so frame_err sees y_nxt.
  assign y_nxt = !hr_fall     ? y
               : (y == Y_MAX) ? y
               : y + 1'b1;

  assign keep = pix_valid
             && (x < H_L) && (y < V_L)
             && ((x & DM_X) == '0)
             && ((y & DM_Y) == '0);

  // line_base tracks (y/DECIM)*(H_ACT/DECIM) by addition only.
  assign base_step = hr_fall
                  && (y_nxt != y)
                  && (y_nxt < V_L)
                  && ((y_nxt & DM_Y) == '0);

  assign addr = line_base + ADDR_W'(x >> SH);

  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= IDLE;
      shot_lock  <= 1'b0;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= 16'h0000;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      frame_cnt  <= 16'h0000;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      we         <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        // A finished single shot stays parked until cap_en is released.
        IDLE: begin
          if (!cap_en) shot_lock <= 1'b0;
          if (cap_en && !shot_lock) begin
            state <= WAIT_SOF;
            busy  <= 1'b1;
          end
        end
        WAIT_SOF: begin
          if (!cap_en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (vs_fall) begin
            state     <= CAPTURE;
            x         <= '0;
            y         <= '0;
            line_base <= '0;
            line_err  <= 1'b0;
            frame_err <= 1'b0;
          end
        end
        CAPTURE: begin
          if (pix_valid) begin
            if (x != X_MAX) x <= x + 1'b1;
            if (keep) begin
              we    <= 1'b1;
              wAddr <= addr;
              wData <= pix_data;
            end
          end
          if (hr_fall) begin
            if (x != H_L) line_err <= 1'b1;
            y <= y_nxt;
            x <= '0;
            if (base_step) line_base <= line_base + W_L;
          end
          if (vs_rise) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            if (y_nxt != V_L) frame_err <= 1'b1;
            if (cap_en && !single_shot) begin
              state <= WAIT_SOF;
            end else begin
              state     <= IDLE;
              busy      <= 1'b0;
              shot_lock <= single_shot;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_capture_ctrl.sv
// Scoreboard bench for ov7670_capture_ctrl.
// Two instances (DECIM=1 and DECIM=2) share the same camera stimulus.
module tb_ov7670_capture_ctrl;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 5;

  logic        pclk = 1'b0;
  logic        reset, href, v_sync, cap_en, single_shot, byte_swap;
  logic [7:0]  ov7670_data;

  logic          a_we, a_busy, a_fd, a_le, a_fe;
  logic [AW-1:0] a_wAddr;
  logic [15:0]   a_wData, a_cnt;
  logic          b_we, b_busy, b_fd, b_le, b_fe;
  logic [AW-1:0] b_wAddr;
  logic [15:0]   b_wData, b_cnt;

  always #5 pclk = ~pclk;

  ov7670_capture_ctrl #(.H_ACT(H), .V_ACT(V), .DECIM(1), .ADDR_W(AW)) u_d1 (
    .pclk(pclk), .reset(reset), .href(href), .v_sync(v_sync),
    .ov7670_data(ov7670_data), .cap_en(cap_en),
    .single_shot(single_shot), .byte_swap(byte_swap),
    .we(a_we), .wAddr(a_wAddr), .wData(a_wData), .busy(a_busy),
    .frame_done(a_fd), .frame_cnt(a_cnt),
    .line_err(a_le), .frame_err(a_fe)
  );

  ov7670_capture_ctrl #(.H_ACT(H), .V_ACT(V), .DECIM(2), .ADDR_W(AW)) u_d2 (
    .pclk(pclk), .reset(reset), .href(href), .v_sync(v_sync),
    .ov7670_data(ov7670_data), .cap_en(cap_en),
    .single_shot(single_shot), .byte_swap(byte_swap),
    .we(b_we), .wAddr(b_wAddr), .wData(b_wData), .busy(b_busy),
    .frame_done(b_fd), .frame_cnt(b_cnt),
    .line_err(b_le), .frame_err(b_fe)
  );

  int errors = 0;
  int checks = 0;
  int qw0[$], qw1[$], qf0[$], qf1[$];
  logic [7:0] lb[$];
  int cnt_m  = 0;
  bit lock_m = 0;
  bit prev0  = 0;
  bit prev1  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge pclk);
      #2;
    end
  endtask

  task automatic mon(input int k, input bit w, input int a, input int d,
                     input bit fd, input int c, input bit le, input bit fe,
                     input bit pw);
    int e, sz;
    if (w) begin
      chk($sformatf("we_gap_%0d", k), int'(pw), 0);
      sz = (k == 0) ? qw0.size() : qw1.size();
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL write_%0d: got addr %0d data 0x%h, expected no write", k, a, d);
      end else begin
        if (k == 0) e = qw0.pop_front();
        else        e = qw1.pop_front();
        chk($sformatf("wAddr_%0d", k), a, e >> 16);
        chk($sformatf("wData_%0d", k), d, e & 'hFFFF);
      end
    end
    if (fd) begin
      sz = (k == 0) ? qf0.size() : qf1.size();
      if (sz == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_done_%0d: got pulse, expected none", k);
      end else begin
        if (k == 0) e = qf0.pop_front();
        else        e = qf1.pop_front();
        chk($sformatf("frame_cnt_%0d", k), c, e >> 2);
        chk($sformatf("line_err_%0d", k), int'(le), (e >> 1) & 1);
        chk($sformatf("frame_err_%0d", k), int'(fe), e & 1);
      end
    end
  endtask

  always @(negedge pclk) begin
    mon(0, a_we, int'(a_wAddr), int'(a_wData), a_fd, int'(a_cnt), a_le, a_fe, prev0);
    mon(1, b_we, int'(b_wAddr), int'(b_wData), b_fd, int'(b_cnt), b_le, b_fe, prev1);
    prev0 = a_we;
    prev1 = b_we;
  end

  // Reference: kept pixel (x,y) lands at (y/D)*(H/D)+x/D.
  task automatic push_line(input int y, input int npix, input bit sw);
    int d, e;
    logic [7:0] b0, b1;
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? 1 : 2;
      for (int p = 0; p < npix; p++) begin
        if (p < H && y < V && p % d == 0 && y % d == 0) begin
          b0 = lb[2*p];
          b1 = lb[2*p+1];
          e  = ((y / d) * (H / d) + p / d) << 16;
          e  = e | (sw ? {b1, b0} : {b0, b1});
          if (k == 0) qw0.push_back(e);
          else        qw1.push_back(e);
        end
      end
    end
  endtask

  task automatic run_frame(input int nl, input int len, input int short_idx,
                           input bit rnd, input int drop_line, input bit do_rst);
    bit cap, lerr;
    int plen, nb, ramp, e;
    ramp = 0;
    lerr = 0;
    href = 0;
    v_sync = 1;
    tick(3);
    cap = cap_en && !lock_m;
    v_sync = 0;
    tick(3);
    if (cap) begin
      chk("sof_line_err", int'(a_le), 0);
      chk("sof_frame_err", int'(b_fe), 0);
      chk("sof_busy", int'(a_busy), 1);
    end
    for (int y = 0; y < nl; y++) begin
      if (y == drop_line) cap_en = 0;
      if (rnd) plen = $urandom_range(len + 1, len - 1);
      else     plen = (y == short_idx) ? len - 1 : len;
      nb = 2 * plen;
      if (rnd && $urandom_range(1, 0) == 1) nb++;
      lb.delete();
      for (int i = 0; i < nb; i++) begin
        if (rnd) lb.push_back(8'($urandom));
        else begin
          lb.push_back(8'(ramp));
          ramp++;
        end
      end
      if (plen != H) lerr = 1;
      if (cap) push_line(y, (do_rst && y == 0) ? 3 : plen, byte_swap);
      href = 1;
      for (int i = 0; i < nb; i++) begin
        ov7670_data = lb[i];
        if (do_rst && y == 0 && i == 7) reset = 1;
        tick(1);
        if (reset) begin
          reset  = 0;
          href   = 0;
          v_sync = 1;
          cnt_m  = 0;
          lock_m = 0;
          chk("rst_we_1", int'(a_we), 0);
          chk("rst_we_2", int'(b_we), 0);
          chk("rst_cnt", int'(a_cnt), 0);
          chk("rst_busy", int'(b_busy), 0);
          tick(4);
          return;
        end
      end
      href = 0;
      tick(3);
    end
    if (cap) begin
      cnt_m++;
      e = ((cnt_m & 'hFFFF) << 2) | (int'(lerr) << 1) | int'(nl != V);
      qf0.push_back(e);
      qf1.push_back(e);
    end
    v_sync = 1;
    tick(6);
    if (cap && single_shot) lock_m = 1;
  endtask

  initial begin
    reset = 1;
    href = 0;
    v_sync = 1;
    cap_en = 0;
    single_shot = 0;
    byte_swap = 0;
    ov7670_data = 8'h00;
    tick(3);
    reset = 0;
    tick(1);
    chk("reset_we", int'(a_we), 0);
    chk("reset_busy", int'(a_busy), 0);
    chk("reset_cnt", int'(b_cnt), 0);
    chk("reset_fd", int'(a_fd), 0);
    chk("reset_lerr", int'(b_le), 0);
    chk("reset_ferr", int'(a_fe), 0);
    chk("reset_wdata", int'(a_wData), 0);

    cap_en = 1;
    tick(3);
    chk("busy_armed", int'(a_busy), 1);
    run_frame(4, H, -1, 0, -1, 0);
    byte_swap = 1;
    run_frame(4, H, -1, 0, -1, 0);
    byte_swap = 0;
    run_frame(3, H, 2, 0, -1, 0);
    run_frame(4, H, -1, 0, -1, 0);

    single_shot = 1;
    run_frame(4, H, -1, 0, -1, 0);
    chk("shot_busy", int'(a_busy), 0);
    run_frame(4, H, -1, 0, -1, 0);
    run_frame(4, H, -1, 0, -1, 0);
    chk("shot_cnt", int'(b_cnt), cnt_m);
    cap_en = 0;
    lock_m = 0;
    tick(3);
    single_shot = 0;

    cap_en = 1;
    tick(3);
    run_frame(4, H, -1, 0, 1, 0);
    chk("drop_busy", int'(b_busy), 0);
    run_frame(4, H, -1, 0, -1, 0);

    cap_en = 1;
    tick(3);
    run_frame(4, H, -1, 0, -1, 1);
    run_frame(4, H, -1, 0, -1, 0);
    chk("after_rst_cnt", int'(a_cnt), 1);

    for (int f = 0; f < 10; f++) begin
      byte_swap = 1'($urandom_range(1, 0));
      run_frame($urandom_range(5, 3), H, -1, 1, -1, 0);
    end
    tick(5);

    chk("final_cnt_1", int'(a_cnt), cnt_m);
    chk("final_cnt_2", int'(b_cnt), cnt_m);
    chk("left_writes_1", qw0.size(), 0);
    chk("left_writes_2", qw1.size(), 0);
    chk("left_frames_1", qf0.size(), 0);
    chk("left_frames_2", qf1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
